// File: rtl/router_pkg.sv
// router_pkg: header layout, length width and FSM states shared by the source arbiter.
package router_pkg;
    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB = 2;
    localparam int LEN_W = 6;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
    typedef enum logic [1:0] {ARB, XFER, PARITY, DROP} state_t;
endpackage

// File: rtl/router_src_arbiter_if.sv
// router_src_arbiter_if: source-side and router-side signals of the packet arbiter.
interface router_src_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int SEL_W = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] src_req;
    logic [NUM_SRC-1:0] src_pkt_valid;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0] src_gnt;
    logic src_ready;
    logic router_busy;
    logic router_pkt_valid;
    logic [7:0] router_data;
    logic [SEL_W-1:0] cur_src;
    logic pkt_done;
    logic drop_pulse;
    logic len_err;
    modport master (
        output src_req, src_pkt_valid, src_data, router_busy,
        input src_gnt, src_ready, router_pkt_valid, router_data, cur_src, pkt_done, drop_pulse, len_err
    );
    modport slave (
        input src_req, src_pkt_valid, src_data, router_busy,
        output src_gnt, src_ready, router_pkt_valid, router_data, cur_src, pkt_done, drop_pulse, len_err
    );
endinterface

// File: rtl/router_src_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int SEL_W = $clog2(NUM_SRC)
) (
    input logic [NUM_SRC-1:0] req,
    input logic [SEL_W-1:0] ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SEL_W-1:0] idx,
    output logic any
);
    logic [SEL_W-1:0] j;
    // scan downward so the candidate closest to ptr is written last and wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = SEL_W'((int'(ptr) + k) % NUM_SRC);
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = j;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/router_src_arbiter.sv
// router_src_arbiter: packet-granular round-robin sharing of the router input among sources.
module router_src_arbiter
    import router_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int SEL_W = $clog2(NUM_SRC)
) (
    input logic clock,
    input logic resetn,
    router_src_arbiter_if.slave bus
);
    state_t state;
    logic [SEL_W-1:0] ptr, cur_src, win;
    logic [NUM_SRC-1:0] gnt_q, win_oh;
    logic [LEN_W-1:0] len, cnt;
    logic hdr_seen, win_any, pv, consume, done;
    logic [7:0] data_arr [NUM_SRC];
    logic [7:0] beat;
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign data_arr[g] = bus.src_data[8*g +: 8];
    end
    rr_arbiter #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_rr (
        .req(bus.src_req), .ptr(ptr), .gnt(win_oh), .idx(win), .any(win_any)
    );
    assign beat = data_arr[cur_src];
    assign pv = bus.src_pkt_valid[cur_src];
    assign consume = state == DROP || (state == XFER && !bus.router_busy);
    assign done = state == XFER && consume && !pv;
    assign bus.src_gnt = (state == XFER || state == DROP) ? gnt_q : '0;
    assign bus.src_ready = consume;
    assign bus.router_pkt_valid = state == XFER && pv;
    assign bus.router_data = state == XFER ? beat : 8'h00;
    assign bus.cur_src = cur_src;
    assign bus.pkt_done = done;
    assign bus.len_err = done && (cnt != len || len == '0);
    assign bus.drop_pulse = state == DROP && !pv;
    // first consumed valid beat is the header; later valid beats are payload
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ARB;
            ptr <= '0;
            cur_src <= '0;
            gnt_q <= '0;
            len <= '0;
            cnt <= '0;
            hdr_seen <= 1'b0;
        end else begin
            case (state)
                ARB: if (!bus.router_busy && win_any) begin
                    cur_src <= win;
                    gnt_q <= win_oh;
                    ptr <= win == SEL_W'(NUM_SRC - 1) ? '0 : win + 1'b1;
                    len <= '0;
                    cnt <= '0;
                    hdr_seen <= 1'b0;
                    state <= data_arr[win][ADDR_LSB +: 2] == ADDR_INVALID ? DROP : XFER;
                end
                XFER: if (consume) begin
                    if (!pv) state <= PARITY;
                    else if (!hdr_seen) begin
                        len <= beat[LEN_LSB +: LEN_W];
                        hdr_seen <= 1'b1;
                    end else cnt <= cnt != '1 ? cnt + 1'b1 : cnt;
                end
                DROP: if (!pv) state <= PARITY;
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: doc/router_src_arbiter.md
# router_src_arbiter

Packet-level round-robin arbiter sharing the single router input port among `NUM_SRC` packet sources. It sits between the source interfaces and the router input (`pkt_valid`, `data_in`, `busy`). It grants one source at a time and holds that grant for a whole packet: header, payload and parity. It forwards only while the router is not busy, discards packets whose header addresses the non-existent port 3, and checks payload length against the header.

## Interface
- `NUM_SRC`, default 3: number of sources, legal range 2..8.
- `SEL_W`, default `$clog2(NUM_SRC)`: width of `cur_src`; derived, do not override.
- `clock` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `src_req` in `NUM_SRC`: source i has a packet pending; its header is valid on `src_data[i]` while the bit is high.
- `src_pkt_valid` in `NUM_SRC`: per-source packet valid; high for header and payload, low for the parity beat.
- `src_data` in `NUM_SRC*8`: source i occupies bits `[8i+7:8i]`.
- `src_gnt` out `NUM_SRC`: one-hot grant, held for the whole packet.
- `src_ready` out 1: the granted source's current beat is consumed this cycle; the source advances only on this.
- `router_busy` in 1: router busy output.
- `router_pkt_valid` out 1: to router `pkt_valid`.
- `router_data` out 8: to router `data_in`.
- `cur_src` out `SEL_W`: index of the granted source.
- `pkt_done` out 1: one-cycle pulse when the parity beat of a forwarded packet is consumed.
- `drop_pulse` out 1: one-cycle pulse when the parity beat of a dropped packet is consumed.
- `len_err` out 1: one-cycle pulse, coincident with `pkt_done`, when the payload beat count differs from the header length.

## Operation
- Header format: `[1:0]` is the destination address (0..2 valid, 3 invalid); `[7:2]` is the payload length L.
- The FSM has four states: ARB, XFER, PARITY and DROP.
- **ARB.** Stays here while `router_busy`=1 or `src_req`=0.
  - Otherwise the round-robin winner w is registered into `cur_src`.
  - If `src_data[w][1:0]`==3, go to DROP; otherwise go to XFER.
- **XFER.** `src_gnt[cur_src]`=1.
  - `router_pkt_valid` = `src_pkt_valid[cur_src]`; `router_data` = `src_data[cur_src]`.
  - `src_ready` = !`router_busy`.
  - On a consumed beat with `src_pkt_valid`=1: the first beat is the header and latches L; each later beat increments the 6-bit payload counter, which saturates at 63.
  - On a consumed beat with `src_pkt_valid`=0: that beat is parity. Pulse `pkt_done`, and pulse `len_err` if count≠L or L==0. Go to PARITY.
- **PARITY.** One-cycle gap: grant low, `router_pkt_valid`=0. Then go to ARB.
  - ARB then waits on `router_busy` while the router finishes its parity check.
- **DROP.** `src_gnt[cur_src]`=1 and `src_ready`=1 every cycle, independent of `router_busy`.
  - `router_pkt_valid`=0 and `router_data`=0.
  - The first beat with `src_pkt_valid`=0 is parity: pulse `drop_pulse`, go to PARITY.
- **Round robin.** The priority pointer p is reset to 0. After a grant to w, p becomes (w+1) mod `NUM_SRC`. The search runs from p upward with wrap.
- **Outside XFER.** `router_pkt_valid` and `router_data` are forced to 0.
- **Mid-packet `src_req` drop.** Ignored; the grant is released only at parity.
- **Reset values.** state ARB, p=0, `cur_src`=0, `src_gnt`=0, `src_ready`=0, `router_pkt_valid`=0, `router_data`=0, all pulses 0, counters 0.
- **Reset mid-packet.** Outputs return to reset values on the next edge. The partial packet is abandoned; no pulse is issued.

## Timing
- Arbitration latency: `src_req` seen in ARB with `router_busy`=0 gives `src_gnt` and the header on `router_data` in the next cycle.
- Forwarding path (`src_*` to `router_*`) is combinational through a mux on registered `cur_src`. No added latency.
- `router_busy`=1 in XFER stalls: `src_ready`=0, the source holds its beat, and counters freeze.
- Minimum spacing between packets: parity, PARITY gap, then ARB. The next header appears ≥2 cycles after the parity beat and never while `router_busy`=1.
- Simultaneous requests are resolved by p only. A single requester is regranted after every packet.

## Structure
- Shared `router_pkg`:
  - header field positions (`ADDR_LSB`, `LEN_LSB`);
  - `ADDR_INVALID` = 2'b11;
  - `LEN_W` = 6;
  - FSM state enum.
- Sub-module `rr_arbiter`: takes `NUM_SRC` requests plus pointer and returns a one-hot winner and its index. Purely combinational; the pointer register lives in the parent.

## Test plan
- Single packet: src1 header 8'h0D (addr 1, L=3), 3 payload beats, parity, with `router_busy`=0 → `src_gnt`=3'b010 one cycle after the request; 5 beats forwarded; one `pkt_done` pulse; `len_err`=0.
- Round robin: all three sources request continuously, one 1-byte packet each → grant order 0,1,2,0; each grant starts ≥2 cycles after the previous parity.
- Busy stall: `router_busy`=1 for 4 cycles mid-payload → `src_ready`=0, `router_data` held, payload count unchanged; transfer resumes on the cycle `router_busy` falls.
- Drop: src2 header 8'h07 (addr 3) → `router_pkt_valid` stays 0 throughout; `src_ready`=1 every cycle; `drop_pulse` on parity; pointer advances to 0.
- Length error: header L=4 but only 2 payload beats before parity → `pkt_done` and `len_err` pulse together.
- Reset mid-packet: `resetn`=0 during the payload → next edge gives `src_gnt`=0 and `router_pkt_valid`=0; after release, src0 wins first.
